// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the add-3 adjust constants and a digit-count helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digits of 2**bin_w-1, i.e. ceil(bin_w*log10(2)); log10(2) ~ 0.30103.
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 32'sd30103 + 32'sd99999) / 32'sd100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: a BCD digit of 5 or more gets 3 added so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  // add-3 when the digit would reach 10 or more after doubling
  always_comb begin
    q = d;
    if (d >= BCD_ADJ_THRESH) begin
      q = d + BCD_ADJ_ADD;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one double-dabble shift per clock, valid/ready on both sides.
// Optional macro BCD_BLANK_EN adds the registered leading-zero mask output out_blank.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]     out_blank,
`endif
  output logic                  out_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [BIN_W-1:0]   bin_sr_r;
  logic [BCD_W-1:0]   bcd_sr_r;
  logic               ovf_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [BCD_W-1:0]   out_bcd_r;
  logic               out_ovf_r;

  logic [BCD_W-1:0]   bcd_adj_s;
  logic [BCD_W-1:0]   bcd_nxt_s;
  logic [BIN_W-1:0]   bin_nxt_s;
  logic               ovf_nxt_s;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (bcd_sr_r[4*i +: 4]),
      .q (bcd_adj_s[4*i +: 4])
    );
  end

  // one shift step: adjusted digits and binary register move left together
  always_comb begin
    bcd_nxt_s = {bcd_adj_s[BCD_W-2:0], bin_sr_r[BIN_W-1]};
    bin_nxt_s = {bin_sr_r[BIN_W-2:0], 1'b0};
    ovf_nxt_s = ovf_r | bcd_adj_s[BCD_W-1];
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt_s;
  logic [DIGITS-1:0] out_blank_r;
  logic              zero_above_s;

  // digit k is blanked when it and every higher digit of the final result are zero
  always_comb begin
    blank_nxt_s  = '0;
    zero_above_s = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (bcd_nxt_s[4*k +: 4] == 4'd0) begin
        zero_above_s = zero_above_s;
      end else begin
        zero_above_s = 1'b0;
      end
      blank_nxt_s[k] = zero_above_s;
    end
  end

  // leading-zero mask is captured together with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_blank_r <= '0;
    end else if (state_r == SHIFT && cnt_r == CNT_ONE) begin
      out_blank_r <= blank_nxt_s;
    end
  end

  assign out_blank = out_blank_r;
`endif

  // converter FSM with registered handshake outputs and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bin_sr_r    <= '0;
      bcd_sr_r    <= '0;
      ovf_r       <= 1'b0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_bcd_r   <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            bin_sr_r   <= in_bin;
            bcd_sr_r   <= '0;
            ovf_r      <= 1'b0;
            cnt_r      <= CNT_LOAD;
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          bin_sr_r <= bin_nxt_s;
          bcd_sr_r <= bcd_nxt_s;
          ovf_r    <= ovf_nxt_s;
          cnt_r    <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            out_bcd_r   <= bcd_nxt_s;
            out_ovf_r   <= ovf_nxt_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          // in_ready stays low here, so no accept can share the output handshake cycle
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_bcd   = out_bcd_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: three configurations (8/3, 8/2, 16/5) driven with
// directed and random values, checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int NI = 3;
  localparam int BWS [NI] = '{8, 8, 16};
  localparam int DGS [NI] = '{3, 2, 5};

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    logic [4:0]  blank;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc  = 0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int inst);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // reference: repeated division by ten, overflow when anything is left over
  function automatic exp_t exp_of(input longint v, input int dg);
    exp_t   e;
    longint r;
    bit     zero;
    r = v;
    e.bcd = '0;
    e.blank = '0;
    e.acc = 0;
    for (int i = 0; i < dg; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.ovf = (r != 0);
    zero = 1'b1;
    for (int k = dg - 1; k >= 1; k--) begin
      zero = zero && (e.bcd[4*k +: 4] == 4'd0);
      e.blank[k] = zero;
    end
    return e;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gd
    localparam int BW = BWS[g];
    localparam int DG = DGS[g];

    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [BW-1:0]    in_bin    = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4*DG-1:0]  out_bcd;
    logic             out_ovf;
`ifdef BCD_BLANK_EN
    logic [DG-1:0]    out_blank;
`endif

    exp_t q[$];
    bit   busy = 1'b0;
    int   since_rst = 0;
    bit   first = 1'b1;
    int   stall_until = 0;
    bit   done = 1'b0;

    bin_to_bcd_seq #(.BIN_W(BW), .DIGITS(DG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
`ifdef BCD_BLANK_EN
      .out_blank (out_blank),
`endif
      .out_ovf   (out_ovf)
    );

    always @(posedge clk) begin
      #1;
      out_ready = (cyc < stall_until) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    // monitor / scoreboard
    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        q.delete();
        busy = 1'b0;
        first = 1'b1;
        since_rst = 0;
        check("rst_out_valid", 32'(out_valid), 32'd0, g);
        check("rst_out_bcd", 32'(out_bcd), 32'd0, g);
        check("rst_out_ovf", 32'(out_ovf), 32'd0, g);
        check("rst_in_ready", 32'(in_ready), 32'd0, g);
      end else begin
        check("in_ready", 32'(in_ready), 32'((since_rst >= 1) && !busy), g);
        if (out_valid) begin
          if (q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0, g);
          end else begin
            e = q[0];
            check("out_bcd", 32'(out_bcd), 32'(e.bcd[4*DG-1:0]), g);
            check("out_ovf", 32'(out_ovf), 32'(e.ovf), g);
`ifdef BCD_BLANK_EN
            check("out_blank", 32'(out_blank), 32'(e.blank[DG-1:0]), g);
`endif
            if (first) check("latency", 32'(cyc), 32'(e.acc + BW), g);
            first = 1'b0;
            if (out_ready) begin
              void'(q.pop_front());
              busy = 1'b0;
              first = 1'b1;
            end
          end
        end
        if (in_valid && in_ready) begin
          e = exp_of(longint'(in_bin), DG);
          e.acc = cyc + 1;
          q.push_back(e);
          busy = 1'b1;
        end
        since_rst++;
      end
    end

    task automatic send(input longint v);
      int n;
      in_bin = BW'(v);
      in_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!in_ready && n < 400);
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1, g);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_bin = BW'($urandom);
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 600) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0, g);
    endtask

    // stimulus
    initial begin
      int gap;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      if (g == 0) begin
        send(255);
        send(0);
        send(9);
        drain();
        stall_until = cyc + 20;
        send(137);
        drain();
        send(200);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0, g);
        check("abort_out_bcd", 32'(out_bcd), 32'd0, g);
        check("abort_in_ready", 32'(in_ready), 32'd0, g);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(42);
        send(7);
      end else if (g == 1) begin
        send(100);
        send(99);
        send(255);
      end else begin
        send(65535);
        send(0);
        send(10000);
      end
      send((64'd1 << BW) - 64'd1);
      for (int i = 0; i < 40; i++) begin
        send(longint'($urandom_range(0, (1 << BW) - 1)));
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(gd[0].done && gd[1].done && gd[2].done) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(gd[0].done && gd[1].done && gd[2].done))
      check("global_timeout", 32'(gd[0].done && gd[1].done && gd[2].done), 32'd1, 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
